// File: rtl/control_botones.sv
`timescale 1ns/1ps
// control_botones: per-button synchronizer, debounce and press/long/release FSM,
// with pending event slots shared onto one valid/ready port by a round-robin arbiter.
module control_botones #(
    parameter int N_BTN        = 4,
    parameter int DEBOUNCE_CNT = 2,
    parameter int LONG_CNT     = 1000,
    parameter int ID_W         = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
    input  logic             clk_slow,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_stable,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [ID_W-1:0]  evt_id,
    output logic [1:0]       evt_tipo,
    output logic             evt_drop
);

    localparam int DB_W   = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam int HOLD_W = $clog2(LONG_CNT);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CNT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CNT - 1);
    localparam logic [ID_W-1:0]   GRANT_RST = ID_W'(N_BTN - 1);

    localparam logic [1:0] TIPO_PRESS   = 2'b00;
    localparam logic [1:0] TIPO_LONG    = 2'b01;
    localparam logic [1:0] TIPO_RELEASE = 2'b10;

    typedef enum logic [1:0] {
        SUELTO    = 2'd0,
        PULSADO   = 2'd1,
        MANTENIDO = 2'd2
    } btn_state_e;

    logic [N_BTN-1:0] raise_s;
    logic [1:0]       raise_tipo_s [N_BTN];

    logic [N_BTN-1:0] pend_v_q;
    logic [1:0]       pend_t_q [N_BTN];
    logic [ID_W-1:0]  last_grant_q;

    logic             evt_valid_q;
    logic [ID_W-1:0]  evt_id_q;
    logic [1:0]       evt_tipo_q;
    logic             evt_drop_q;

    logic             load_s;
    logic             gnt_found_s;
    logic [ID_W-1:0]  gnt_idx_s;
    logic [ID_W-1:0]  scan_idx_s;
    logic [N_BTN-1:0] clr_s;
    logic             drop_s;

    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        logic              sync1_q;
        logic              sync2_q;
        logic              stable_q;
        logic [DB_W-1:0]   db_cnt_q;
        logic              commit_s;
        logic              rise_s;
        logic              fall_s;
        btn_state_e        st_q;
        logic [HOLD_W-1:0] hold_q;
        logic              ev_s;
        logic [1:0]        ev_tipo_s;

        assign commit_s = (sync2_q != stable_q) && (db_cnt_q == DB_LAST);
        assign rise_s   = commit_s & sync2_q;
        assign fall_s   = commit_s & ~sync2_q;

        // Synchronize the raw pin and accept a new level only after an unbroken disagreeing run.
        always_ff @(posedge clk_slow) begin
            if (rst) begin
                sync1_q  <= 1'b0;
                sync2_q  <= 1'b0;
                stable_q <= 1'b0;
                db_cnt_q <= '0;
            end else begin
                sync1_q <= btn_in[g];
                sync2_q <= sync1_q;
                if (sync2_q == stable_q) begin
                    db_cnt_q <= '0;
                end else if (db_cnt_q == DB_LAST) begin
                    stable_q <= sync2_q;
                    db_cnt_q <= '0;
                end else begin
                    db_cnt_q <= db_cnt_q + 1'b1;
                end
            end
        end

        // Press/long/release state; hold_q counts cycles since the PRESS edge.
        always_ff @(posedge clk_slow) begin
            if (rst) begin
                st_q   <= SUELTO;
                hold_q <= '0;
            end else begin
                case (st_q)
                    SUELTO: begin
                        if (rise_s) begin
                            st_q   <= PULSADO;
                            hold_q <= '0;
                        end
                    end
                    PULSADO: begin
                        if (fall_s) begin
                            st_q <= SUELTO;
                        end else if (hold_q == HOLD_LAST) begin
                            st_q <= MANTENIDO;
                        end else begin
                            hold_q <= hold_q + 1'b1;
                        end
                    end
                    MANTENIDO: begin
                        if (fall_s) begin
                            st_q <= SUELTO;
                        end
                    end
                    default: begin
                        st_q <= SUELTO;
                    end
                endcase
            end
        end

        // Event strobe raised on the same edge as the matching state transition; release beats long.
        always_comb begin
            ev_s      = 1'b0;
            ev_tipo_s = TIPO_PRESS;
            case (st_q)
                SUELTO: begin
                    if (rise_s) begin
                        ev_s = 1'b1;
                    end else begin
                        ev_s = 1'b0;
                    end
                end
                PULSADO: begin
                    if (fall_s) begin
                        ev_s      = 1'b1;
                        ev_tipo_s = TIPO_RELEASE;
                    end else if (hold_q == HOLD_LAST) begin
                        ev_s      = 1'b1;
                        ev_tipo_s = TIPO_LONG;
                    end else begin
                        ev_s = 1'b0;
                    end
                end
                MANTENIDO: begin
                    if (fall_s) begin
                        ev_s      = 1'b1;
                        ev_tipo_s = TIPO_RELEASE;
                    end else begin
                        ev_s = 1'b0;
                    end
                end
                default: begin
                    ev_s = 1'b0;
                end
            endcase
        end

        assign raise_s[g]      = ev_s;
        assign raise_tipo_s[g] = ev_tipo_s;
        assign btn_stable[g]   = stable_q;
    end

    assign load_s = ~evt_valid_q | evt_ready;

    // Round-robin search over registered slots, starting just after the last grant.
    always_comb begin
        gnt_found_s = 1'b0;
        gnt_idx_s   = '0;
        scan_idx_s  = '0;
        for (int k = 1; k <= N_BTN; k++) begin
            scan_idx_s = ID_W'((int'(last_grant_q) + k) % N_BTN);
            if (!gnt_found_s && pend_v_q[scan_idx_s]) begin
                gnt_found_s = 1'b1;
                gnt_idx_s   = scan_idx_s;
            end else begin
                gnt_found_s = gnt_found_s;
            end
        end
    end

    // A new event hitting a still-occupied slot (not drained this cycle) is an overwrite.
    always_comb begin
        clr_s = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (load_s && gnt_found_s && (gnt_idx_s == ID_W'(i))) begin
                clr_s[i] = 1'b1;
            end else begin
                clr_s[i] = 1'b0;
            end
        end
        drop_s = |(raise_s & pend_v_q & ~clr_s);
    end

    // Pending slots and the output register; the payload only moves on a load opportunity.
    always_ff @(posedge clk_slow) begin
        if (rst) begin
            pend_v_q     <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                pend_t_q[i] <= TIPO_PRESS;
            end
            last_grant_q <= GRANT_RST;
            evt_valid_q  <= 1'b0;
            evt_id_q     <= '0;
            evt_tipo_q   <= TIPO_PRESS;
            evt_drop_q   <= 1'b0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (raise_s[i]) begin
                    pend_v_q[i] <= 1'b1;
                    pend_t_q[i] <= raise_tipo_s[i];
                end else if (clr_s[i]) begin
                    pend_v_q[i] <= 1'b0;
                end
            end
            evt_drop_q <= drop_s;
            if (load_s) begin
                if (gnt_found_s) begin
                    evt_valid_q  <= 1'b1;
                    evt_id_q     <= gnt_idx_s;
                    evt_tipo_q   <= pend_t_q[gnt_idx_s];
                    last_grant_q <= gnt_idx_s;
                end else begin
                    evt_valid_q <= 1'b0;
                end
            end
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_id    = evt_id_q;
    assign evt_tipo  = evt_tipo_q;
    assign evt_drop  = evt_drop_q;

endmodule

// File: tb/tb_control_botones.sv
`timescale 1ns/1ps
// Bench for control_botones: directed scenarios plus random button activity,
// every cycle compared with an event-level reference model.
module tb_control_botones;

    localparam int N   = 4;
    localparam int DEB = 2;
    localparam int LNG = 1000;

    logic         clk_slow = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] btn_in = '0;
    logic         evt_ready = 1'b0;
    logic [N-1:0] btn_stable;
    logic         evt_valid;
    logic [1:0]   evt_id;
    logic [1:0]   evt_tipo;
    logic         evt_drop;

    control_botones #(.N_BTN(N), .DEBOUNCE_CNT(DEB), .LONG_CNT(LNG)) dut (
        .clk_slow  (clk_slow),
        .rst       (rst),
        .btn_in    (btn_in),
        .btn_stable(btn_stable),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_id    (evt_id),
        .evt_tipo  (evt_tipo),
        .evt_drop  (evt_drop)
    );

    always #5 clk_slow = ~clk_slow;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // reference model state: delayed samples, disagreement run, hold age, slots, output
    bit m_s1 [N];
    bit m_s2 [N];
    bit m_stab [N];
    int m_run [N];
    bit m_pr [N];
    bit m_longd [N];
    int m_held [N];
    bit m_pv [N];
    int m_pt [N];
    bit m_ov;
    int m_oid;
    int m_ot;
    int m_lg = N - 1;
    bit m_drop;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic model_step();
        bit ev [N];
        int evt [N];
        bit found;
        int g;
        int idx;
        bit dn;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_stab[i] = 0; m_run[i] = 0;
                m_pr[i] = 0; m_longd[i] = 0; m_held[i] = 0; m_pv[i] = 0; m_pt[i] = 0;
            end
            m_ov = 0; m_oid = 0; m_ot = 0; m_lg = N - 1; m_drop = 0;
            return;
        end
        for (int i = 0; i < N; i++) begin
            ev[i] = 0;
            evt[i] = 0;
            if (m_s2[i] != m_stab[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_stab[i] = m_s2[i];
                    m_run[i] = 0;
                    ev[i] = 1;
                    evt[i] = m_stab[i] ? 0 : 2;
                end
            end else begin
                m_run[i] = 0;
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = btn_in[i];
            if (ev[i] && evt[i] == 0) begin
                m_pr[i] = 1; m_held[i] = 0; m_longd[i] = 0;
            end else if (ev[i]) begin
                m_pr[i] = 0;
            end else if (m_pr[i] && !m_longd[i]) begin
                m_held[i]++;
                if (m_held[i] == LNG) begin
                    m_longd[i] = 1;
                    ev[i] = 1;
                    evt[i] = 1;
                end
            end
        end
        if (!m_ov || evt_ready) begin
            found = 0;
            g = 0;
            for (int k = 1; k <= N; k++) begin
                idx = (m_lg + k) % N;
                if (!found && m_pv[idx]) begin
                    found = 1;
                    g = idx;
                end
            end
            if (found) begin
                m_ov = 1; m_oid = g; m_ot = m_pt[g]; m_pv[g] = 0; m_lg = g;
            end else begin
                m_ov = 0;
            end
        end
        dn = 0;
        for (int i = 0; i < N; i++) begin
            if (ev[i]) begin
                if (m_pv[i]) dn = 1;
                m_pv[i] = 1;
                m_pt[i] = evt[i];
            end
        end
        m_drop = dn;
    endtask

    task automatic compare_all();
        logic [N-1:0] sv;
        for (int i = 0; i < N; i++) sv[i] = m_stab[i];
        chk("btn_stable", 32'(btn_stable), 32'(sv));
        chk("evt_valid", 32'(evt_valid), 32'(m_ov));
        chk("evt_drop", 32'(evt_drop), 32'(m_drop));
        if (m_ov) begin
            chk("evt_id", 32'(evt_id), 32'(m_oid));
            chk("evt_tipo", 32'(evt_tipo), 32'(m_ot));
        end
    endtask

    task automatic tick();
        @(posedge clk_slow);
        model_step();
        @(negedge clk_slow);
        cyc++;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    int press_cyc;
    int long_cyc;
    int rel_seen;
    int drops;
    int hits;
    int p;

    initial begin
        // reset held with all buttons pressed
        rst = 1'b1; btn_in = 4'b1111; evt_ready = 1'b0;
        idle(3);
        chk("rst_stable", 32'(btn_stable), 32'd0);
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_id", 32'(evt_id), 32'd0);
        chk("rst_tipo", 32'(evt_tipo), 32'd0);
        chk("rst_drop", 32'(evt_drop), 32'd0);
        rst = 1'b0; evt_ready = 1'b1;
        idle(3);
        chk("post_rst_stable_early", 32'(btn_stable), 32'd0);
        tick();
        chk("post_rst_stable", 32'(btn_stable), 32'hf);
        for (int i = 0; i < N; i++) begin
            tick();
            chk("post_rst_valid", 32'(evt_valid), 32'd1);
            chk("post_rst_id", 32'(evt_id), 32'(i));
            chk("post_rst_tipo", 32'(evt_tipo), 32'd0);
        end
        btn_in = '0;
        idle(12);

        // clean press and release of button 2
        for (int ph = 0; ph < 2; ph++) begin
            btn_in[2] = (ph == 0);
            idle(3);
            chk("clean_stable_early", 32'(btn_stable[2]), 32'(ph != 0));
            tick();
            chk("clean_stable", 32'(btn_stable[2]), 32'(ph == 0));
            chk("clean_valid_early", 32'(evt_valid), 32'd0);
            tick();
            chk("clean_valid", 32'(evt_valid), 32'd1);
            chk("clean_id", 32'(evt_id), 32'd2);
            chk("clean_tipo", 32'(evt_tipo), (ph == 0) ? 32'd0 : 32'd2);
            idle(4);
        end

        // bounce on button 0
        hits = 0;
        for (int j = 0; j < 14; j++) begin
            btn_in[0] = (j < 4) && (j % 2 == 0);
            tick();
            if (btn_stable[0]) hits++;
            if (evt_valid) hits++;
        end
        chk("bounce_hits", 32'(hits), 32'd0);

        // long press on button 1
        press_cyc = -1; long_cyc = -1; drops = 0; rel_seen = 0;
        btn_in[1] = 1'b1;
        for (int j = 0; j < 1200; j++) begin
            tick();
            if (evt_valid && evt_id == 2'd1 && evt_tipo == 2'b00) press_cyc = cyc;
            if (evt_valid && evt_id == 2'd1 && evt_tipo == 2'b01) long_cyc = cyc;
            if (evt_drop) drops++;
        end
        btn_in[1] = 1'b0;
        for (int j = 0; j < 10; j++) begin
            tick();
            if (evt_valid && evt_id == 2'd1 && evt_tipo == 2'b10) rel_seen++;
            if (evt_drop) drops++;
        end
        chk("long_gap", 32'(long_cyc - press_cyc), 32'(LNG));
        chk("long_release", 32'(rel_seen), 32'd1);
        chk("long_drops", 32'(drops), 32'd0);

        // tap button 0 so button 1 has next priority
        btn_in[0] = 1'b1; idle(8);
        btn_in[0] = 1'b0; idle(8);

        // simultaneous press on 1 and 3 under backpressure
        evt_ready = 1'b0;
        btn_in[1] = 1'b1; btn_in[3] = 1'b1;
        idle(5);
        chk("arb_first_valid", 32'(evt_valid), 32'd1);
        chk("arb_first_id", 32'(evt_id), 32'd1);
        idle(3);
        chk("arb_hold_id", 32'(evt_id), 32'd1);
        chk("arb_hold_tipo", 32'(evt_tipo), 32'd0);
        evt_ready = 1'b1;
        tick();
        chk("arb_second_id", 32'(evt_id), 32'd3);
        chk("arb_second_valid", 32'(evt_valid), 32'd1);
        btn_in[1] = 1'b0; btn_in[3] = 1'b0;
        idle(20);

        // overwrite: press+release of button 0 while output is stuck on button 2
        evt_ready = 1'b0; drops = 0;
        btn_in[2] = 1'b1;
        for (int j = 0; j < 6; j++) begin tick(); if (evt_drop) drops++; end
        btn_in[0] = 1'b1;
        for (int j = 0; j < 8; j++) begin tick(); if (evt_drop) drops++; end
        btn_in[0] = 1'b0;
        for (int j = 0; j < 8; j++) begin tick(); if (evt_drop) drops++; end
        chk("ovw_drops", 32'(drops), 32'd1);
        chk("ovw_stuck_id", 32'(evt_id), 32'd2);
        evt_ready = 1'b1;
        tick();
        chk("ovw_survivor_id", 32'(evt_id), 32'd0);
        chk("ovw_survivor_tipo", 32'(evt_tipo), 32'd2);
        btn_in[2] = 1'b0;
        idle(10);

        // random activity: fast toggling with a mid-run reset, then slow holds
        for (int ph = 0; ph < 2; ph++) begin
            p = (ph == 0) ? 8 : 1500;
            for (int j = 0; j < ((ph == 0) ? 3000 : 8000); j++) begin
                for (int i = 0; i < N; i++)
                    if ($urandom_range(p - 1, 0) == 0) btn_in[i] = ~btn_in[i];
                evt_ready = ($urandom_range(9, 0) < ((ph == 0) ? 7 : 9));
                rst = (ph == 0) && (j >= 1500) && (j < 1502);
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
